gate3_bist_checker: RTL

GATE3_BIST_CHECKER -- requirements
Module: gate3_bist_checker

---
 rtl/gate3_pkg.sv | 24 ++
 rtl/gate3_ref_model.sv | 26 ++
 rtl/gate3_bist_checker.sv | 123 ++++++++++++
 3 files changed

// File: rtl/gate3_pkg.sv
// Shared definitions for the 3-input gate BIST checker: gate codes,
// FSM state encoding and the legal dwell range.
package gate3_pkg;

  localparam logic [2:0] GS_AND  = 3'd0;
  localparam logic [2:0] GS_OR   = 3'd1;
  localparam logic [2:0] GS_XOR  = 3'd2;
  localparam logic [2:0] GS_XNOR = 3'd3;
  localparam logic [2:0] GS_NAND = 3'd4;
  localparam logic [2:0] GS_NOR  = 3'd5;

  localparam int DWELL_MIN = 2;
  localparam int DWELL_MAX = 16;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DRIVE = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  function automatic logic sel_legal(input logic [2:0] sel);
    return (sel <= GS_NOR);
  endfunction

endpackage

// File: rtl/gate3_ref_model.sv
// Combinational golden model of the gate under test; reserved codes
// return 0 and are never evaluated during a run.
module gate3_ref_model
  import gate3_pkg::*;
(
  input  logic [2:0] gate_sel,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic       f_exp
);

  always_comb begin
    f_exp = 1'b0;
    case (gate_sel)
      GS_AND:  f_exp = a & b & c;
      GS_OR:   f_exp = a | b | c;
      GS_XOR:  f_exp = a ^ b ^ c;
      GS_XNOR: f_exp = ~(a ^ b ^ c);
      GS_NAND: f_exp = ~(a & b & c);
      GS_NOR:  f_exp = ~(a | b | c);
      default: f_exp = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate3_bist_checker.sv
// Exhaustive 3-input gate tester: walks patterns 0..7, holds each for
// DWELL cycles and compares the response on the last dwell cycle.
//
//   state    | meaning
//   ST_IDLE  | waiting for start, stimulus parked at 000
//   ST_DRIVE | applying pattern, sampling f at dwell end
//   ST_DONE  | one-cycle completion pulse, results final
module gate3_bist_checker
  import gate3_pkg::*;
#(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] gate_sel,
  output logic       a,
  output logic       b,
  output logic       c,
  input  logic       f,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_cnt,
  output logic [2:0] first_fail,
  output logic       cfg_err
);

  localparam logic [3:0] LP_LAST = 4'(DWELL - 1);

  state_t     r_state;
  logic [2:0] r_sel;
  logic [2:0] r_pattern;
  logic [3:0] r_dwell;
  logic [3:0] r_err_cnt;
  logic [2:0] r_first_fail;
  logic       r_pass;
  logic       r_cfg_err;

  logic       w_f_exp;
  logic       w_mismatch;
  logic [3:0] w_err_next;

  gate3_ref_model u_ref (
    .gate_sel (r_sel),
    .a        (r_pattern[2]),
    .b        (r_pattern[1]),
    .c        (r_pattern[0]),
    .f_exp    (w_f_exp)
  );

  assign w_mismatch = w_f_exp ^ f;
  assign w_err_next = r_err_cnt + {3'b000, w_mismatch};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_sel        <= GS_AND;
      r_pattern    <= 3'd0;
      r_dwell      <= 4'd0;
      r_err_cnt    <= 4'd0;
      r_first_fail <= 3'd0;
      r_pass       <= 1'b0;
      r_cfg_err    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_pattern    <= 3'd0;
            r_dwell      <= 4'd0;
            r_err_cnt    <= 4'd0;
            r_first_fail <= 3'd0;
            r_pass       <= 1'b0;
            if (sel_legal(gate_sel)) begin
              r_state   <= ST_DRIVE;
              r_sel     <= gate_sel;
              r_cfg_err <= 1'b0;
            end else begin
              r_state   <= ST_DONE;
              r_cfg_err <= 1'b1;
            end
          end
        end
        ST_DRIVE: begin
          if (r_dwell == LP_LAST) begin
            r_err_cnt <= w_err_next;
            if (w_mismatch && (r_err_cnt == 4'd0)) begin
              r_first_fail <= r_pattern;
            end
            r_dwell <= 4'd0;
            // Pattern returns to 000 on the way out so DONE/IDLE see a parked bus.
            if (r_pattern == 3'd7) begin
              r_state   <= ST_DONE;
              r_pattern <= 3'd0;
              r_pass    <= (w_err_next == 4'd0);
            end else begin
              r_pattern <= r_pattern + 3'd1;
            end
          end else begin
            r_dwell <= r_dwell + 4'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign a          = r_pattern[2];
  assign b          = r_pattern[1];
  assign c          = r_pattern[0];
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign pass       = r_pass;
  assign err_cnt    = r_err_cnt;
  assign first_fail = r_first_fail;
  assign cfg_err    = r_cfg_err;

endmodule
